// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 2-of-3 vote at bit centre, optional parity,
// one-entry holding register with valid/ready handshake and error pulses.
module uart_rx #(
  parameter int SYS_CLK    = 50000000,
  parameter int BAUD       = 115200,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  // state  | meaning
  // IDLE   | line idle, waiting for a falling edge
  // START  | start bit, glitch rejection at its centre
  // DATA   | eight data bits, LSB first
  // PARITY | parity bit (PARITY_EN only)
  // STOP   | stop bit, decided at its centre
  // BRK    | stop bit was 0, wait for the line to return high
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK} state_t;

  localparam int          DIV_I  = (SYS_CLK + 8 * BAUD) / (16 * BAUD);
  localparam logic [15:0] DIV_M1 = 16'(DIV_I - 1);

  if (DIV_I < 2) begin : g_div_chk
    $error("uart_rx: baud divider must be at least 2");
  end

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [15:0] div_q, div_d;
  logic [3:0]  samp_q, samp_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        s7_q, s7_d, s8_q, s8_d;
  logic        par_err_q, par_err_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        parity_err_q, parity_err_d;
  logic        overrun_q, overrun_d;

  logic rxd_s, tick, at_s9, at_s15, vote, deliver;

  assign rxd_s  = sync2_q;
  assign tick   = (div_q == DIV_M1);
  assign at_s9  = tick && (samp_q == 4'd9);
  assign at_s15 = tick && (samp_q == 4'd15);
  assign vote   = (s7_q & s8_q) | (s7_q & rxd_s) | (s8_q & rxd_s);

  always_comb begin
    state_d      = state_q;
    div_d        = tick ? 16'd0 : div_q + 16'd1;
    samp_d       = tick ? samp_q + 4'd1 : samp_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    s7_d         = s7_q;
    s8_d         = s8_q;
    par_err_d    = par_err_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;
    deliver      = 1'b0;

    if (tick && samp_q == 4'd7) s7_d = rxd_s;
    if (tick && samp_q == 4'd8) s8_d = rxd_s;

    case (state_q)
      S_IDLE: begin
        // counters held at zero so bit centres line up with the start edge
        div_d     = 16'd0;
        samp_d    = 4'd0;
        par_err_d = 1'b0;
        if (!rxd_s) state_d = S_START;
      end
      S_START: begin
        if (at_s9 && vote) state_d = S_IDLE;
        else if (at_s15) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (at_s9) shift_d[idx_q] = vote;
        if (at_s15) begin
          if (idx_q == 3'd7) state_d = PARITY_EN ? S_PARITY : S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (at_s9)  par_err_d = vote ^ (^shift_q) ^ PARITY_ODD;
        if (at_s15) state_d   = S_STOP;
      end
      S_STOP: begin
        if (at_s9) begin
          if (!vote) begin
            frame_err_d = 1'b1;
            state_d     = S_BRK;
          end else if (par_err_q) begin
            parity_err_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_BRK: begin
        div_d  = 16'd0;
        samp_d = 4'd0;
        if (rxd_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      div_q        <= 16'd0;
      samp_q       <= 4'd0;
      idx_q        <= 3'd0;
      shift_q      <= 8'd0;
      s7_q         <= 1'b1;
      s8_q         <= 1'b1;
      par_err_q    <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= rxd;
      sync2_q      <= sync1_q;
      div_q        <= div_d;
      samp_q       <= samp_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      s7_q         <= s7_d;
      s8_q         <= s8_d;
      par_err_q    <= par_err_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance at DIV=27 (432 clk/bit) and an
// 8E1 instance at DIV=4 (64 clk/bit) sharing clock and reset.
module tb_uart_rx;

  localparam int BT  = 432;
  localparam int BTP = 64;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       rxd = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun;
  logic       rxd_p = 1'b1, rx_ready_p = 1'b1;
  logic [7:0] rx_data_p;
  logic       rx_valid_p, frame_err_p, parity_err_p, overrun_p;

  always #5 clk = ~clk;

  uart_rx #(.SYS_CLK(50000000), .BAUD(115200)) dut (
    .clk(clk), .n_rst(n_rst), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun));

  uart_rx #(.SYS_CLK(50000000), .BAUD(781250), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk(clk), .n_rst(n_rst), .rxd(rxd_p), .rx_data(rx_data_p), .rx_valid(rx_valid_p),
    .rx_ready(rx_ready_p), .frame_err(frame_err_p), .parity_err(parity_err_p), .overrun(overrun_p));

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // event counters, sampled away from the active edge
  int v_cnt = 0, fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, rise_cyc = 0;
  int vp_cnt = 0, fep_cnt = 0, pep_cnt = 0;
  logic [7:0] last_d = 8'h00, last_dp = 8'h00;
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (rx_valid) begin v_cnt++; last_d = rx_data; end
    if (rx_valid && !prev_v) rise_cyc = cyc;
    prev_v = rx_valid;
    if (frame_err) fe_cnt++;
    if (parity_err) pe_cnt++;
    if (overrun) ov_cnt++;
    if (rx_valid_p) begin vp_cnt++; last_dp = rx_data_p; end
    if (frame_err_p) fep_cnt++;
    if (parity_err_p) pep_cnt++;
  end

  int b_v, b_fe, b_pe, b_ov, b_vp, b_fep, b_pep;
  task automatic snap();
    b_v = v_cnt; b_fe = fe_cnt; b_pe = pe_cnt; b_ov = ov_cnt;
    b_vp = vp_cnt; b_fep = fep_cnt; b_pep = pep_cnt;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // drives n bits LSB first, each bclk cycles long; called at a negedge
  task automatic send_bits(input logic [15:0] bits, input int n, input int bclk, input bit to_p);
    for (int i = 0; i < n; i++) begin
      if (to_p) rxd_p = bits[i];
      else      rxd   = bits[i];
      repeat (bclk) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk);
    send_bits({6'b0, stop, d, 1'b0}, 10, bclk, 1'b0);
  endtask

  typedef struct {
    logic [7:0] data;
    int         bclk;
    logic [7:0] exp_d;
  } vec_t;
  vec_t tbl[5];

  int lat, t0;

  initial begin
    tbl[0] = '{8'hFF, BT,  8'hFF};
    tbl[1] = '{8'h96, 445, 8'h96};
    tbl[2] = '{8'h69, 445, 8'h69};
    tbl[3] = '{8'hC3, 419, 8'hC3};
    tbl[4] = '{8'h3A, 419, 8'h3A};

    repeat (3) @(negedge clk);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset rx_data", rx_data, 0);
    chk("reset errs", {frame_err, parity_err, overrun}, 0);
    n_rst = 1'b1;
    repeat (BT) @(negedge clk);

    // single 8N1 frame with latency measurement
    snap();
    t0 = cyc;
    send_frame(8'hA5, 1'b1, BT);
    repeat (4) @(negedge clk);
    lat = rise_cyc - t0;
    chk("A5 valid cycles", v_cnt - b_v, 1);
    chk("A5 data", last_d, 8'hA5);
    chk("A5 no errors", (fe_cnt - b_fe) + (pe_cnt - b_pe) + (ov_cnt - b_ov), 0);
    chk("A5 latency window", (lat >= 9 * BT + BT / 2 && lat <= 9 * BT + BT / 2 + 80), 1);

    // back-to-back frames, nominal and +/-3% baud
    for (int i = 0; i < 5; i++) begin
      snap();
      send_frame(tbl[i].data, 1'b1, tbl[i].bclk);
      chk($sformatf("vec%0d valid cycles", i), v_cnt - b_v, 1);
      chk($sformatf("vec%0d data", i), last_d, tbl[i].exp_d);
      chk($sformatf("vec%0d errors", i), (fe_cnt - b_fe) + (pe_cnt - b_pe), 0);
    end
    repeat (BT) @(negedge clk);

    // glitch shorter than half a bit, then a clean frame
    snap();
    rxd = 1'b0;
    repeat (81) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BT) @(negedge clk);
    chk("glitch no output", v_cnt - b_v, 0);
    chk("glitch no flag", (fe_cnt - b_fe) + (pe_cnt - b_pe), 0);
    send_frame(8'h3C, 1'b1, BT);
    chk("3C data", last_d, 8'h3C);
    chk("3C valid cycles", v_cnt - b_v, 1);

    // stop bit low followed by a long break
    snap();
    send_bits({7'b0, 8'h55, 1'b0}, 9, BT, 1'b0);
    rxd = 1'b0;
    repeat (20 * BT) @(negedge clk);
    chk("break frame_err once", fe_cnt - b_fe, 1);
    chk("break no output", v_cnt - b_v, 0);
    rxd = 1'b1;
    repeat (BT) @(negedge clk);
    send_frame(8'h81, 1'b1, BT);
    chk("81 after break", last_d, 8'h81);
    chk("81 valid cycles", v_cnt - b_v, 1);
    chk("break single flag", fe_cnt - b_fe, 1);

    // backpressure and overrun
    snap();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, BT);
    send_frame(8'h22, 1'b1, BT);
    chk("overrun pulses", ov_cnt - b_ov, 1);
    chk("held valid", rx_valid, 1);
    chk("held data", rx_data, 8'h11);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    chk("consume clears valid", rx_valid, 0);
    chk("consume keeps data", rx_data, 8'h11);

    // even parity: 0x07 needs parity bit 1
    snap();
    send_bits({5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, BTP, 1'b1);
    repeat (BTP) @(negedge clk);
    chk("bad parity pulse", pep_cnt - b_pep, 1);
    chk("bad parity no output", vp_cnt - b_vp, 0);
    snap();
    send_bits({5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, BTP, 1'b1);
    repeat (BTP) @(negedge clk);
    chk("good parity output", vp_cnt - b_vp, 1);
    chk("good parity data", last_dp, 8'h07);
    chk("good parity no err", (pep_cnt - b_pep) + (fep_cnt - b_fep), 0);

    // reset mid-frame with a byte held
    send_frame(8'h5A, 1'b1, BT);
    chk("5A held", {rx_valid, rx_data}, {1'b1, 8'h5A});
    send_bits({11'b0, 4'h0, 1'b0}, 5, BT, 1'b0);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("async reset valid", rx_valid, 0);
    chk("async reset data", rx_data, 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    rx_ready = 1'b1;
    snap();
    repeat (2 * BT) @(negedge clk);
    chk("no output after reset", v_cnt - b_v, 0);
    send_frame(8'h0F, 1'b1, BT);
    repeat (4) @(negedge clk);
    chk("0F after reset", last_d, 8'h0F);
    chk("0F valid cycles", v_cnt - b_v, 1);
    chk("0F no errors", (fe_cnt - b_fe) + (pe_cnt - b_pe) + (ov_cnt - b_ov), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
